rope_ctrl: RTL and testbench

ROPE_CTRL -- requirements
Module: rope_ctrl

---
 rtl/rope_pkg.sv | 27 ++
 rtl/rope_ctrl_vsync_tick.sv | 22 ++
 rtl/rope_ctrl.sv | 128 ++++++++++++
 tb/tb_rope_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/rope_pkg.sv
// Shared types and default constants for the tug-of-war rope controller.
package rope_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_COUNTDOWN = 2'd1,
    ST_PLAY      = 2'd2,
    ST_WIN       = 2'd3
  } state_t;

  localparam logic [1:0] WIN_NONE  = 2'b00;
  localparam logic [1:0] WIN_LEFT  = 2'b01;
  localparam logic [1:0] WIN_RIGHT = 2'b10;

  localparam logic [9:0] DEF_ROPE_CENTER      = 10'd320;
  localparam logic [9:0] DEF_WIN_MARGIN       = 10'd200;
  localparam int         DEF_STEP             = 4;
  localparam int         DEF_COUNTDOWN_FRAMES = 180;
  localparam int         DEF_WIN_HOLD_FRAMES  = 300;

  // Per-frame pull counters stick at 15 rather than wrapping.
  function automatic logic [3:0] sat_inc4(input logic [3:0] v, input logic inc);
    if (inc && v != 4'd15) return v + 4'd1;
    return v;
  endfunction

endpackage

// File: rtl/rope_ctrl_vsync_tick.sv
// One-cycle frame tick, registered one cycle after the falling edge of vsync.
module vsync_tick (
  input  logic clk,
  input  logic rstn,
  input  logic vsync,
  output logic tick
);

  logic vs_q;

  // History resets high so leaving reset while vsync is high cannot fire a tick.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vs_q <= 1'b1;
      tick <= 1'b0;
    end else begin
      vs_q <= vsync;
      tick <= vs_q & ~vsync;
    end
  end

endmodule

// File: rtl/rope_ctrl.sv
// Game sequencer and rope position integrator for a two-player tug-of-war display.
module rope_ctrl
  import rope_pkg::*;
#(
  parameter logic [9:0] ROPE_CENTER      = DEF_ROPE_CENTER,
  parameter logic [9:0] WIN_MARGIN       = DEF_WIN_MARGIN,
  parameter int         STEP             = DEF_STEP,
  parameter int         COUNTDOWN_FRAMES = DEF_COUNTDOWN_FRAMES,
  parameter int         WIN_HOLD_FRAMES  = DEF_WIN_HOLD_FRAMES
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       i_vsync,
  input  logic       i_start,
  input  logic       i_pull_l,
  input  logic       i_pull_r,
  output logic [9:0] o_rope_loc,
  output logic [1:0] o_state,
  output logic [1:0] o_winner,
  output logic       o_song_start
);

  localparam logic [9:0]        LOC_LO    = ROPE_CENTER - WIN_MARGIN;
  localparam logic [9:0]        LOC_HI    = ROPE_CENTER + WIN_MARGIN;
  localparam logic signed [11:0] LO_S     = $signed({2'b00, LOC_LO});
  localparam logic signed [11:0] HI_S     = $signed({2'b00, LOC_HI});
  localparam logic signed [11:0] STEP_S   = 12'(STEP);
  localparam logic [9:0]        CD_LAST   = 10'(COUNTDOWN_FRAMES - 1);
  localparam logic [9:0]        HOLD_LAST = 10'(WIN_HOLD_FRAMES - 1);

  state_t            state, state_next;
  logic              tick;
  logic [9:0]        frame_cnt;
  logic [3:0]        cnt_l, cnt_r;
  logic [9:0]        rope_loc;
  logic [1:0]        winner;
  logic              song_start;
  logic signed [11:0] diff, delta, sum;
  logic [9:0]        loc_upd;

  function automatic logic [9:0] clamp_loc(input logic signed [11:0] v);
    if (v < LO_S) return LOC_LO;
    if (v > HI_S) return LOC_HI;
    return 10'(v);
  endfunction

  vsync_tick u_vsync_tick (
    .clk   (clk),
    .rstn  (rstn),
    .vsync (i_vsync),
    .tick  (tick)
  );

  always_comb begin
    diff    = $signed({8'b0, cnt_r}) - $signed({8'b0, cnt_l});
    delta   = diff * STEP_S;
    sum     = $signed({2'b00, rope_loc}) + delta;
    loc_upd = clamp_loc(sum);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_next;
  end

  // A bound reached on the previous update ends the game on the following cycle.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:      if (i_start) state_next = ST_COUNTDOWN;
      ST_COUNTDOWN: if (tick && frame_cnt == CD_LAST) state_next = ST_PLAY;
      ST_PLAY:      if (rope_loc == LOC_LO || rope_loc == LOC_HI) state_next = ST_WIN;
      ST_WIN:       if (tick && frame_cnt == HOLD_LAST) state_next = ST_IDLE;
      default:      state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      frame_cnt  <= '0;
      cnt_l      <= '0;
      cnt_r      <= '0;
      rope_loc   <= ROPE_CENTER;
      winner     <= WIN_NONE;
      song_start <= 1'b0;
    end else begin
      song_start <= (state_next == ST_PLAY) && (state != ST_PLAY);
      cnt_l      <= '0;
      cnt_r      <= '0;
      case (state)
        ST_IDLE: begin
          frame_cnt <= '0;
          rope_loc  <= ROPE_CENTER;
          winner    <= WIN_NONE;
        end
        ST_COUNTDOWN: if (tick) frame_cnt <= frame_cnt + 10'd1;
        ST_PLAY: begin
          if (state_next == ST_WIN) begin
            winner    <= (rope_loc == LOC_LO) ? WIN_LEFT : WIN_RIGHT;
            frame_cnt <= '0;
          end else if (tick) begin
            // Pulls landing on the tick cycle seed the next frame's counts.
            rope_loc <= loc_upd;
            cnt_l    <= {3'b000, i_pull_l};
            cnt_r    <= {3'b000, i_pull_r};
          end else begin
            cnt_l <= sat_inc4(cnt_l, i_pull_l);
            cnt_r <= sat_inc4(cnt_r, i_pull_r);
          end
        end
        ST_WIN: begin
          if (tick) frame_cnt <= frame_cnt + 10'd1;
          if (state_next == ST_IDLE) begin
            rope_loc <= ROPE_CENTER;
            winner   <= WIN_NONE;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_rope_loc   = rope_loc;
  assign o_state      = state;
  assign o_winner     = winner;
  assign o_song_start = song_start;

endmodule

// File: tb/tb_rope_ctrl.sv
// Directed bench for rope_ctrl with a short countdown and win hold.
module tb_rope_ctrl;

  logic       clk = 1'b0;
  logic       rstn;
  logic       i_vsync;
  logic       i_start;
  logic       i_pull_l;
  logic       i_pull_r;
  logic [9:0] o_rope_loc;
  logic [1:0] o_state;
  logic [1:0] o_winner;
  logic       o_song_start;

  int checks = 0;
  int errors = 0;

  rope_ctrl #(
    .COUNTDOWN_FRAMES (3),
    .WIN_HOLD_FRAMES  (2)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .i_vsync      (i_vsync),
    .i_start      (i_start),
    .i_pull_l     (i_pull_l),
    .i_pull_r     (i_pull_r),
    .o_rope_loc   (o_rope_loc),
    .o_state      (o_state),
    .o_winner     (o_winner),
    .o_song_start (o_song_start)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic pull(input logic l, input logic r, input int n);
    for (int i = 0; i < n; i++) begin
      i_pull_l = l;
      i_pull_r = r;
      cyc();
    end
    i_pull_l = 1'b0;
    i_pull_r = 1'b0;
  endtask

  // Falling vsync edge, then one cycle for the tick to act.
  task automatic frame();
    i_vsync = 1'b0;
    cyc();
    i_vsync = 1'b1;
    cyc();
  endtask

  task automatic start_game();
    i_start = 1'b1;
    cyc();
    i_start = 1'b0;
    check("start_to_countdown", 12'(o_state), 12'd1);
    pull(1'b0, 1'b1, 4);
    frame();
    frame();
    check("countdown_hold", 12'(o_state), 12'd1);
    frame();
    check("play_entry", 12'(o_state), 12'd2);
    check("song_start_pulse", 12'(o_song_start), 12'd1);
    check("loc_at_play", 12'(o_rope_loc), 12'd320);
    cyc();
    check("song_start_single", 12'(o_song_start), 12'd0);
  endtask

  initial begin
    rstn     = 1'b1;
    i_vsync  = 1'b1;
    i_start  = 1'b0;
    i_pull_l = 1'b0;
    i_pull_r = 1'b0;
    #2 rstn = 1'b0;
    #1;
    check("rst_state", 12'(o_state), 12'd0);
    check("rst_loc", 12'(o_rope_loc), 12'd320);
    check("rst_winner", 12'(o_winner), 12'd0);
    check("rst_song", 12'(o_song_start), 12'd0);
    cyc();
    cyc();
    rstn = 1'b1;
    cyc();

    start_game();

    pull(1'b0, 1'b1, 5);
    pull(1'b1, 1'b0, 2);
    frame();
    check("net_pull_loc", 12'(o_rope_loc), 12'd332);

    i_start = 1'b1;
    cyc();
    i_start = 1'b0;
    check("start_ignored_play", 12'(o_state), 12'd2);

    pull(1'b1, 1'b1, 3);
    pull(1'b1, 1'b0, 3);
    frame();
    check("coincident_pulls", 12'(o_rope_loc), 12'd320);

    pull(1'b0, 1'b1, 20);
    frame();
    check("saturate_right", 12'(o_rope_loc), 12'd380);

    i_vsync = 1'b0;
    cyc();
    i_vsync = 1'b1;
    i_pull_l = 1'b1;
    cyc();
    i_pull_l = 1'b0;
    check("tick_pull_excluded", 12'(o_rope_loc), 12'd380);
    frame();
    check("tick_pull_next", 12'(o_rope_loc), 12'd376);

    for (int f = 0; f < 4; f++) begin
      pull(1'b1, 1'b0, 15);
      frame();
    end
    check("left_walk", 12'(o_rope_loc), 12'd136);
    pull(1'b1, 1'b0, 2);
    frame();
    check("loc_128", 12'(o_rope_loc), 12'd128);
    check("still_play", 12'(o_state), 12'd2);

    pull(1'b1, 1'b0, 3);
    frame();
    check("clamp_low", 12'(o_rope_loc), 12'd120);
    cyc();
    check("win_state", 12'(o_state), 12'd3);
    check("win_left", 12'(o_winner), 12'd1);

    i_start = 1'b1;
    cyc();
    i_start = 1'b0;
    check("start_ignored_win", 12'(o_state), 12'd3);
    pull(1'b0, 1'b1, 5);
    frame();
    check("win_frozen_loc", 12'(o_rope_loc), 12'd120);
    check("win_frozen_winner", 12'(o_winner), 12'd1);
    check("win_hold_state", 12'(o_state), 12'd3);
    frame();
    check("hold_done_state", 12'(o_state), 12'd0);
    check("hold_done_loc", 12'(o_rope_loc), 12'd320);
    check("hold_done_winner", 12'(o_winner), 12'd0);

    start_game();
    pull(1'b0, 1'b1, 13);
    frame();
    check("loc_372", 12'(o_rope_loc), 12'd372);
    #2 rstn = 1'b0;
    #1;
    check("midplay_rst_state", 12'(o_state), 12'd0);
    check("midplay_rst_loc", 12'(o_rope_loc), 12'd320);
    check("midplay_rst_song", 12'(o_song_start), 12'd0);
    cyc();
    rstn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      check("no_tick_after_rst", 12'(dut.u_vsync_tick.tick), 12'd0);
      check("idle_after_rst", 12'(o_state), 12'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
